// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_e     - controller states
//   MODE_DIV/MUL - encodings of mode_i
//   width_legal - elaboration-time check of the WIDTH parameter
package muldiv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StDivZero,
        StDone
    } state_e;

    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_MUL = 1'b1;

    // Operand width must be even and within 8..64.
    function automatic bit width_legal(input int unsigned w);
        return (w >= 8) && (w <= 64) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle for muldiv_unit.
//   master: drives start_i, mode_i, signed_i, opdata_1_i, opdata_2_i, annul_i
//           and observes result_o, ready_o, busy_o, div_zero_o.
//   slave : the unit side of the same signals.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic               mode_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata_1_i;
    logic [WIDTH-1:0]   opdata_2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               div_zero_o;

    modport master (
        output start_i, mode_i, signed_i, opdata_1_i, opdata_2_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, mode_i, signed_i, opdata_1_i, opdata_2_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation, purely combinational.
// Used both to take operand magnitudes and to restore result signs.
//   value_i  - input word
//   negate_i - 1: output -value_i, 0: pass through
//   value_o  - result
module muldiv_signfix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);
    assign value_o = negate_i ? ((~value_i) + WIDTH'(1)) : value_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, operating on magnitudes with sign restored on output.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - muldiv_if slave: start/mode/signed/operands/annul in,
//              result/ready/busy/div_zero out
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    if (!width_legal(WIDTH)) begin : gen_width_check
        $error("muldiv_unit: illegal WIDTH %0d", WIDTH);
    end

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;       // multiplicand magnitude
    logic [WIDTH-1:0]     b_q, b_d;       // divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;   // {partial, multiplier} or {remainder, quotient}
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 neg_qp_q, neg_qp_d; // negate quotient / product
    logic                 neg_r_q, neg_r_d;   // negate remainder
    logic                 dz_q, dz_d;

    logic [WIDTH-1:0]     op1_mag, op2_mag;
    logic [WIDTH-1:0]     quo_fixed, rem_fixed;
    logic [2*WIDTH-1:0]   prod_fixed;

    muldiv_signfix #(.WIDTH(WIDTH)) u_op1_mag (
        .value_i  (bus.opdata_1_i),
        .negate_i (bus.signed_i & bus.opdata_1_i[WIDTH-1]),
        .value_o  (op1_mag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_op2_mag (
        .value_i  (bus.opdata_2_i),
        .negate_i (bus.signed_i & bus.opdata_2_i[WIDTH-1]),
        .value_o  (op2_mag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_quo_fix (
        .value_i  (acc_q[WIDTH-1:0]),
        .negate_i (neg_qp_q),
        .value_o  (quo_fixed)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_rem_fix (
        .value_i  (acc_q[2*WIDTH-1:WIDTH]),
        .negate_i (neg_r_q),
        .value_o  (rem_fixed)
    );

    muldiv_signfix #(.WIDTH(2 * WIDTH)) u_prod_fix (
        .value_i  (acc_q),
        .negate_i (neg_qp_q),
        .value_o  (prod_fixed)
    );

    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor; a borrow (diff[WIDTH]) means restore.
    logic [WIDTH:0]       rem_ext, diff;
    logic [2*WIDTH-1:0]   div_step;
    assign rem_ext  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_ext - {1'b0, b_q};
    assign div_step = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Shift-add multiply step: add multiplicand on multiplier LSB, shift right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    logic last_iter;
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        neg_qp_d = neg_qp_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.annul_i) begin
                    a_d      = op1_mag;
                    b_d      = op2_mag;
                    mode_d   = bus.mode_i;
                    cnt_d    = '0;
                    neg_qp_d = bus.signed_i & (bus.opdata_1_i[WIDTH-1] ^ bus.opdata_2_i[WIDTH-1]);
                    neg_r_d  = bus.signed_i & bus.opdata_1_i[WIDTH-1];
                    dz_d     = 1'b0;
                    if (bus.mode_i == MODE_MUL) begin
                        acc_d   = {{WIDTH{1'b0}}, op2_mag};
                        state_d = StMul;
                    end else if (bus.opdata_2_i == '0) begin
                        acc_d   = '0;
                        dz_d    = 1'b1;
                        state_d = StDivZero;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, op1_mag};
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) state_d = StDone;
            end
            StDiv: begin
                acc_d = div_step;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) state_d = StDone;
            end
            StDivZero: state_d = StDone;
            StDone: begin
                if (!bus.start_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including a held start_i in DONE.
        if (state_q != StIdle && bus.annul_i) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_DIV;
            neg_qp_q <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            neg_qp_q <= neg_qp_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
        end
    end

    // Outputs are gated by state so reset clears them without waiting for clk.
    always_comb begin
        bus.result_o   = '0;
        bus.div_zero_o = 1'b0;
        if (state_q == StDone) begin
            bus.result_o   = (mode_q == MODE_MUL) ? prod_fixed : {rem_fixed, quo_fixed};
            bus.div_zero_o = dz_q;
        end
    end

    assign bus.ready_o = (state_q == StDone);
    assign bus.busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus32 ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          w8;
        bit          mode;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          cyc;
        bit          dz;
    } vec_t;

    function automatic logic [63:0] cur_result(input bit w8);
        return w8 ? {48'b0, bus8.result_o} : bus32.result_o;
    endfunction
    function automatic logic cur_ready(input bit w8);
        return w8 ? bus8.ready_o : bus32.ready_o;
    endfunction
    function automatic logic cur_busy(input bit w8);
        return w8 ? bus8.busy_o : bus32.busy_o;
    endfunction
    function automatic logic cur_dz(input bit w8);
        return w8 ? bus8.div_zero_o : bus32.div_zero_o;
    endfunction

    task automatic drive(input bit w8, input bit st, input bit mode, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start_i = st; bus8.mode_i = mode; bus8.signed_i = sgn;
            bus8.opdata_1_i = a[7:0]; bus8.opdata_2_i = b[7:0];
        end else begin
            bus32.start_i = st; bus32.mode_i = mode; bus32.signed_i = sgn;
            bus32.opdata_1_i = a; bus32.opdata_2_i = b;
        end
    endtask

    // Start edge is the edge before start_i is driven; cycles counts edges
    // from there until ready_o is seen. Operands are scrambled after capture.
    task automatic run_op(input string tag, input vec_t v, input bit hold);
        int cycles = 0;
        bit rdy = 1'b0;
        @(posedge clk); #1;
        drive(v.w8, 1'b1, v.mode, v.sgn, v.a, v.b);
        while (!rdy && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) drive(v.w8, hold, ~v.mode, ~v.sgn, ~v.a, ~v.b);
            rdy = cur_ready(v.w8);
        end
        check({tag, "_ready"}, 64'(rdy), 64'd1);
        check({tag, "_cycles"}, 64'(cycles), 64'(v.cyc));
        check({tag, "_result"}, cur_result(v.w8), v.res);
        check({tag, "_divzero"}, 64'(cur_dz(v.w8)), 64'(v.dz));
        if (hold) begin
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_hold_ready"}, 64'(cur_ready(v.w8)), 64'd1);
            check({tag, "_hold_result"}, cur_result(v.w8), v.res);
            drive(v.w8, 1'b0, ~v.mode, ~v.sgn, ~v.a, ~v.b);
        end
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 64'(cur_busy(v.w8)), 64'd0);
        check({tag, "_idle_result"}, cur_result(v.w8), 64'd0);
    endtask

    vec_t vecs32[9];
    vec_t vecs8[4];
    vec_t v;
    bit   seen;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs32[0] = '{0, 0, 0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0};
        vecs32[1] = '{0, 0, 1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0};
        vecs32[2] = '{0, 0, 1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0};
        vecs32[3] = '{0, 0, 1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0};
        vecs32[4] = '{0, 0, 0, 32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF, 33, 0};
        vecs32[5] = '{0, 0, 0, 32'd5, 32'd0, 64'h0, 2, 1};
        vecs32[6] = '{0, 1, 1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 33, 0};
        vecs32[7] = '{0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33, 0};
        vecs32[8] = '{0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFA, 64'd24, 33, 0};
        vecs8[0]  = '{1, 0, 0, 32'd200, 32'd3, 64'h0242, 9, 0};
        vecs8[1]  = '{1, 1, 0, 32'd200, 32'd3, 64'h0258, 9, 0};
        vecs8[2]  = '{1, 0, 1, 32'h80, 32'hFF, 64'h0080, 9, 0};
        vecs8[3]  = '{1, 0, 1, 32'h85, 32'h00, 64'h0, 2, 1};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus32.annul_i = 1'b0;
        bus8.annul_i  = 1'b0;

        #2;
        check("rst_busy", 64'(bus32.busy_o), 64'd0);
        check("rst_ready", 64'(bus32.ready_o), 64'd0);
        check("rst_result", bus32.result_o, 64'd0);
        check("rst_divzero", 64'(bus32.div_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op($sformatf("w32_vec%0d", i), vecs32[i], 1'b0);

        // Abort a divide ten cycles in; no ready may ever appear for it.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        bus32.start_i = 1'b0;
        seen = bus32.ready_o;
        repeat (9) begin
            @(posedge clk); #1;
            seen |= bus32.ready_o;
        end
        bus32.annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_busy", 64'(bus32.busy_o), 64'd0);
        bus32.annul_i = 1'b0;
        repeat (40) begin
            seen |= bus32.ready_o;
            @(posedge clk); #1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        v = '{0, 1, 0, 32'd9, 32'd9, 64'd81, 33, 0};
        run_op("mul_after_annul", v, 1'b1);

        // Asynchronous reset between edges in the middle of a multiply.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd12, 32'd13);
        @(posedge clk); #1;
        bus8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus8.busy_o), 64'd0);
        check("midrst_ready", 64'(bus8.ready_o), 64'd0);
        check("midrst_result", {48'b0, bus8.result_o}, 64'd0);
        check("midrst_divzero", 64'(bus8.div_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_op($sformatf("w8_vec%0d", i), vecs8[i], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; legal values are even integers 8..64.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start_i  in  1  request a new operation; sampled only in IDLE.
REQ-005 Port: mode_i  in  1  operation select: 0=divide, 1=multiply.
REQ-006 Port: signed_i  in  1  operands are two's complement when 1, unsigned when 0.
REQ-007 Port: opdata_1_i  in  WIDTH  dividend or multiplicand.
REQ-008 Port: opdata_2_i  in  WIDTH  divisor or multiplier.
REQ-009 Port: annul_i  in  1  abort the operation in flight.
REQ-010 Port: result_o  out  2*WIDTH  result. Divide: {remainder, quotient}, upper half to HI and lower half to LO. Multiply: full product.
REQ-011 Port: ready_o  out  1  result_o is valid.
REQ-012 Port: busy_o  out  1  high in every state except IDLE.
REQ-013 Port: div_zero_o  out  1  the completed divide had divisor 0; qualified by ready_o.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, MUL, DIV, DIVZERO and DONE.
REQ-015 In IDLE, a start_i=1 with annul_i=0 SHALL capture the operands, mode_i and signed_i, and clear the iteration counter.
- If signed_i=1, the unit SHALL store the operand magnitudes and a result sign.
- The next state SHALL be MUL for mode_i=1.
- The next state SHALL be DIVZERO for mode_i=0 with opdata_2_i=0.
- Otherwise the next state SHALL be DIV.
REQ-016 DIV SHALL perform restoring division, producing one quotient bit per cycle for exactly WIDTH cycles, then go to DONE.
REQ-017 MUL SHALL perform shift-add multiplication, consuming one multiplier bit per cycle for exactly WIDTH cycles, then go to DONE.
REQ-018 DIVZERO SHALL last one cycle, then go to DONE with a zero result and div_zero_o=1.
REQ-019 Latency:
- DIV and MUL SHALL assert ready_o in the cycle beginning WIDTH+1 rising edges after the start edge.
- DIVZERO SHALL assert ready_o in the cycle beginning 2 edges after the start edge.
REQ-020 Signed sign correction:
- The quotient SHALL be negated when the operand signs differ.
- The remainder SHALL take the sign of the dividend.
- The product SHALL be negated when the operand signs differ.
REQ-021 Signed divide of the most-negative value by -1 SHALL return quotient = most-negative value (wrap) and remainder 0, with no flag.
REQ-022 DONE SHALL hold ready_o=1 and a stable result_o while start_i=1, and SHALL return to IDLE on the first cycle with start_i=0.
REQ-023 result_o and div_zero_o SHALL be zero in every state except DONE.
REQ-024 annul_i=1 in MUL, DIV, DIVZERO or DONE SHALL force IDLE at the next edge.
- ready_o SHALL NOT assert for the annulled operation.
- annul_i SHALL take priority over start_i.
REQ-025 Operand and control input changes after capture SHALL have no effect.
REQ-026 start_i SHALL be ignored outside IDLE.
REQ-027 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide, and SHALL NOT wrap within an operation.

Reset
REQ-028 rst=1 SHALL immediately force IDLE regardless of clk, with ready_o, busy_o, div_zero_o and result_o all zero.
REQ-029 Reset mid-operation SHALL discard all operation state, and ready_o SHALL NOT assert for that operation.
REQ-030 The first start_i after rst deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package muldiv_pkg SHALL hold:
- the state enumeration;
- the MODE_DIV/MODE_MUL constants;
- the width-legality check function.
REQ-032 The sub-module muldiv_signfix SHALL be used for both operand magnitude extraction and result negation.
- It SHALL be combinational.
- It SHALL be parametrised by WIDTH.

Verification
REQ-033 Unsigned divide, WIDTH=32, 100/7 -> result_o=64'h00000002_0000000E, ready_o 33 cycles after start, div_zero_o=0.
REQ-034 Signed divide, -7/2 -> result_o=64'hFFFFFFFF_FFFFFFFD; signed -2^31/-1 -> result_o=64'h00000000_80000000.
REQ-035 Divide by zero, 5/0 -> ready_o 2 cycles after start, div_zero_o=1, result_o=0.
REQ-036 Signed multiply -3*5 -> result_o=64'hFFFFFFFF_FFFFFFF1 after 33 cycles; unsigned 32'hFFFFFFFF squared -> 64'hFFFFFFFE_00000001.
REQ-037 annul_i pulsed 10 cycles into a divide -> busy_o=0 next cycle and ready_o never asserted; an immediate new 9*9 multiply then returns 81.
REQ-038 rst asserted between clock edges mid-multiply -> outputs zero immediately; with WIDTH=8, a subsequent unsigned 200/3 -> result_o=16'h0242 after 9 cycles.
